// File: rtl/aes_byte_ctrl.sv
// Byte-serial front end for the AES-256 core: gathers a 256-bit key and 128-bit blocks, runs the core, streams the result out.
// Latency: core_start is high the cycle after the 16th block byte; result byte 0 is valid the cycle after core_done.
// Backpressure: in_ready drops outside LOAD_KEY/LOAD_DATA (and on a re-key request); out_data/out_valid hold until out_ready.
module aes_byte_ctrl #(
  parameter int KEY_BYTES = 32,
  parameter int BLK_BYTES = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         new_key,
  output logic [255:0] key_out,
  output logic         key_valid,
  output logic [127:0] block_out,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    ST_LOAD_KEY,
    ST_LOAD_DATA,
    ST_START,
    ST_WAIT,
    ST_SEND
  } state_t;

  localparam logic [5:0] KEY_LAST    = 6'(KEY_BYTES - 1);
  localparam logic [5:0] BLK_LAST    = 6'(BLK_BYTES - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t       state;
  logic [5:0]   cnt;
  logic [7:0]   timer;
  logic [127:0] out_shift;

  logic key_acc;
  logic blk_acc;
  logic rekey;
  logic key_last;
  logic blk_last;
  logic done_hit;
  logic tmo_hit;
  logic out_acc;
  logic send_last;

  // The low byte of the shift register is always the byte on offer.
  assign out_data = out_shift[7:0];

  // Input acceptance: open while loading, closed while a re-key is pending at a block boundary.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_LOAD_KEY:  in_ready = 1'b1;
      ST_LOAD_DATA: in_ready = !(new_key && (cnt == 6'd0));
      default:      in_ready = 1'b0;
    endcase
  end

  // Event decode shared by the FSM and the datapath registers.
  assign key_acc   = (state == ST_LOAD_KEY) && in_valid;
  assign blk_acc   = (state == ST_LOAD_DATA) && in_valid && in_ready;
  assign rekey     = (state == ST_LOAD_DATA) && new_key && (cnt == 6'd0);
  assign key_last  = key_acc && (cnt == KEY_LAST);
  assign blk_last  = blk_acc && (cnt == BLK_LAST);
  assign done_hit  = (state == ST_WAIT) && core_done;
  assign tmo_hit   = (state == ST_WAIT) && !core_done && (timer == TIMEOUT_CNT);
  assign out_acc   = (state == ST_SEND) && out_ready;
  assign send_last = out_acc && (cnt == BLK_LAST);

  // Byte counter: cleared explicitly at every terminal count so it never wraps.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= 6'd0;
    end else if (key_last || blk_last || done_hit || tmo_hit || send_last) begin
      cnt <= 6'd0;
    end else if (key_acc || blk_acc || out_acc) begin
      cnt <= cnt + 6'd1;
    end
  end

  // Key assembly: byte n lands at bits [8n+7:8n]; the key persists until overwritten by a reload.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      key_out <= '0;
    end else if (key_acc) begin
      key_out[{cnt[4:0], 3'b000} +: 8] <= in_data;
    end
  end

  // Block assembly: holds from START until the next block byte is written.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      block_out <= '0;
    end else if (blk_acc) begin
      block_out[{cnt[3:0], 3'b000} +: 8] <= in_data;
    end
  end

  // Result shift register: captures the ciphertext on done and shifts one byte per accepted output.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_shift <= '0;
    end else if (done_hit) begin
      out_shift <= core_result;
    end else if (out_acc) begin
      out_shift <= {8'h00, out_shift[127:8]};
    end
  end

  // Wait timer: zeroed in START, counts every WAIT cycle without done until the abort point.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      timer <= 8'd0;
    end else if (state == ST_START) begin
      timer <= 8'd0;
    end else if ((state == ST_WAIT) && !core_done && !tmo_hit) begin
      timer <= timer + 8'd1;
    end
  end

  // Sequencer with registered handshake and status outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= ST_LOAD_KEY;
      key_valid  <= 1'b0;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_LOAD_KEY: begin
          if (key_last) begin
            key_valid <= 1'b1;
            state     <= ST_LOAD_DATA;
          end
        end
        ST_LOAD_DATA: begin
          if (rekey) begin
            key_valid <= 1'b0;
            state     <= ST_LOAD_KEY;
          end else if (blk_last) begin
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          core_start <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_hit) begin
            out_valid <= 1'b1;
            state     <= ST_SEND;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_LOAD_DATA;
          end
        end
        ST_SEND: begin
          if (send_last) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_LOAD_DATA;
          end
        end
        default: begin
          state <= ST_LOAD_KEY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_ctrl.sv
// Bench for aes_byte_ctrl: drives byte streams and a stand-in core, compares against a byte-list reference.
module tb_aes_byte_ctrl;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         new_key = 1'b0;
  logic [255:0] key_out;
  logic         key_valid;
  logic [127:0] block_out;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         err;

  int checks = 0;
  int failures = 0;

  // Reference: the key the controller should currently hold.
  logic [255:0] ref_key = '0;

  aes_byte_ctrl #(.KEY_BYTES(32), .BLK_BYTES(16), .TIMEOUT(255)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .new_key(new_key),
    .key_out(key_out), .key_valid(key_valid), .block_out(block_out),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one byte and wait (bounded) until it is taken.
  task automatic feed(input logic [7:0] b, input string nm);
    bit done = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!done) begin
      @(negedge Clk);
      if (in_ready) done = 1;
      tick();
      n++;
      if (!done && n > 400) begin
        checks++; failures++;
        $display("FAIL %s accept_timeout in_ready=%0b required 1", nm, in_ready);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [255:0] k);
    for (int i = 0; i < 32; i++) feed(k[8*i +: 8], "key_byte");
    ref_key = k;
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL key_valid got=%0b exp=1", key_valid); end
    checks++; if (key_out !== ref_key) begin failures++; $display("FAIL key_out got=%h exp=%h", key_out, ref_key); end
  endtask

  // Load a block; new_key is raised just before byte nk_at (negative: never).
  task automatic load_block(input logic [127:0] blk, input int nk_at);
    for (int i = 0; i < 16; i++) begin
      if (i == nk_at) new_key = 1'b1;
      feed(blk[8*i +: 8], "blk_byte");
    end
    checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL start_pulse got=%0b exp=1", core_start); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_start got=%0b exp=1", busy); end
    checks++; if (block_out !== blk) begin failures++; $display("FAIL block_out got=%h exp=%h", block_out, blk); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL key_kept got=%0b exp=1", key_valid); end
    tick();
    new_key = 1'b0;
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL start_width got=%0b exp=0", core_start); end
  endtask

  // Stand-in core: one-cycle done pulse, then byte 0 must be on offer the next cycle.
  task automatic do_core(input logic [127:0] res);
    core_result = res;
    core_done   = 1'b1;
    tick();
    core_done = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL done_latency out_valid=%0b exp=1", out_valid); end
    checks++; if (out_data !== res[7:0]) begin failures++; $display("FAIL first_byte got=%h exp=%h", out_data, res[7:0]); end
  endtask

  // Drain 16 output bytes; mode 0 ready always, 1 alternating, 2 random.
  task automatic collect(input logic [127:0] res, input int mode);
    logic [7:0] got[$];
    int cyc = 0;
    bit prev_stall = 0;
    logic [7:0] prev_dat = 8'h00;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    while (got.size() < 16 && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge Clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL in_ready_send got=%0b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL out_valid_send got=%0b exp=1", out_valid); end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_dat) begin failures++; $display("FAIL hold got=%h exp=%h", out_data, prev_dat); end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (got.size() == 16) in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (got.size() != 16) begin failures++; $display("FAIL out_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== res[8*i +: 8]) begin failures++; $display("FAIL out_byte%0d got=%h exp=%h", i, got[i], res[8*i +: 8]); end
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL out_valid_end got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_end got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL in_ready_end got=%0b exp=1", in_ready); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL key_valid_end got=%0b exp=1", key_valid); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (key_out !== '0 || block_out !== '0) begin failures++; $display("FAIL reset_regs key=%h blk=%h exp=0", key_out, block_out); end
    checks++; if ({key_valid, core_start, out_valid, busy, err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {key_valid, core_start, out_valid, busy, err});
    end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    #10 Rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [255:0] k;
    logic [127:0] b;
    for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) b[8*i +: 8] = 8'(i);
    load_key(k);
    checks++; if (key_out !== 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100) begin
      failures++; $display("FAIL key_literal got=%h", key_out);
    end
    load_block(b, -1);
    checks++; if (block_out !== 128'h0F0E0D0C0B0A09080706050403020100) begin failures++; $display("FAIL blk_literal got=%h", block_out); end
    do_core(128'h00112233445566778899AABBCCDDEEFF);
    collect(128'h00112233445566778899AABBCCDDEEFF, 0);
  endtask

  task automatic test_toggle_ready();
    logic [127:0] r;
    r = rand128();
    load_block(rand128(), -1);
    do_core(r);
    collect(r, 1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      logic [127:0] r;
      r = rand128();
      load_block(rand128(), -1);
      repeat ($urandom_range(0, 5)) tick();
      do_core(r);
      collect(r, 2);
    end
  endtask

  task automatic test_new_key();
    logic [127:0] r;
    new_key  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge Clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rekey_in_ready got=%0b exp=0", in_ready); end
    tick();
    new_key  = 1'b0;
    in_valid = 1'b0;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rekey_key_valid got=%0b exp=0", key_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rekey_load got=%0b exp=1", in_ready); end
    load_key({rand128(), rand128()});
    r = rand128();
    load_block(rand128(), 5);
    do_core(r);
    collect(r, 0);
  endtask

  task automatic test_timeout();
    int n = 0;
    logic [127:0] r;
    load_block(rand128(), -1);
    repeat (248) tick();
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL early_timeout err=%0b busy=%0b exp 0 1", err, busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL wait_in_ready got=%0b exp=0", in_ready); end
    while (err !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%0b exp=1", err); end
    checks++; if (busy !== 1'b0 || key_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_state busy=%0b key_valid=%0b in_ready=%0b exp 0 1 1", busy, key_valid, in_ready);
    end
    core_result = rand128();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL late_done out_valid=%0b busy=%0b exp 0 0", out_valid, busy); end
    r = rand128();
    load_block(rand128(), -1);
    do_core(r);
    collect(r, 0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    k = {rand128(), rand128()};
    new_key = 1'b1;
    tick();
    new_key = 1'b0;
    for (int i = 0; i < 10; i++) feed(8'($urandom), "pre_reset");
    #3 Rst = 1'b0;
    #1;
    checks++; if (key_out !== '0 || block_out !== '0 || out_data !== 8'h00) begin
      failures++; $display("FAIL mid_reset_regs key=%h blk=%h dat=%h exp=0", key_out, block_out, out_data);
    end
    checks++; if ({key_valid, core_start, out_valid, busy, err} !== 5'b0) begin
      failures++; $display("FAIL mid_reset_flags got=%b exp=00000", {key_valid, core_start, out_valid, busy, err});
    end
    @(negedge Clk);
    #1 Rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", in_ready); end
    for (int i = 0; i < 16; i++) feed(k[8*i +: 8], "half_key");
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL half_key_valid got=%0b exp=0", key_valid); end
    for (int i = 16; i < 32; i++) feed(k[8*i +: 8], "rest_key");
    checks++; if (key_valid !== 1'b1 || key_out !== k) begin
      failures++; $display("FAIL reload_key valid=%0b got=%h exp=%h", key_valid, key_out, k);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_toggle_ready();
    test_back_to_back();
    test_new_key();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
